// File: rtl/uart_pkg.sv
// uart_pkg: types, constants and helpers shared by the UART transmit path.
//   tx_state_t   - serialiser states (IDLE, START, DATA, PARITY, STOP)
//   WLS_*        - LCR word-length-select encodings (5..8 data bits)
//   lcr_cfg_t    - line-control fields latched at the start of every frame
//   calc_parity  - parity bit for a data byte under a given LCR setting
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  typedef struct packed {
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sticky;
    logic       stb;
  } lcr_cfg_t;

  // Mask selecting the data bits that are actually sent for a word length.
  function automatic logic [7:0] wls_mask(input logic [1:0] wls);
    logic [7:0] m;
    case (wls)
      WLS_5:   m = 8'h1F;
      WLS_6:   m = 8'h3F;
      WLS_7:   m = 8'h7F;
      WLS_8:   m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Sticky parity ignores the data and sends ~eps (eps=1 -> constant 0).
  function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] wls,
                                       input logic eps, input logic sticky);
    logic x;
    x = ^(data & wls_mask(wls));
    if (sticky) return ~eps;
    return eps ? x : ~x;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with registered occupancy.
//   clk, rst      - clock, synchronous active-high reset
//   wr_en, din    - write strobe/data; ignored while full
//   rd_en, dout   - pop strobe; dout is the current head (first-word fall-through)
//   level         - occupancy 0..DEPTH, updates the cycle after a write/pop
//   full, empty   - derived only from the registered level
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             do_wr;
  logic             do_rd;

  assign full  = (level_reg == LW'(DEPTH));
  assign empty = (level_reg == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign level = level_reg;

  // Head is read combinationally so the consumer can pop and capture it in
  // the same cycle.
  assign dout = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: 16550-style transmitter with a transmit FIFO.
//   clk, rst              - clock, synchronous active-high reset
//   baud_pulse            - oversample tick, OVERSAMPLE ticks per bit
//   set_break             - forces tx low without stopping the serialiser
//   sticky_parity/eps/pen/stb/wls - LCR fields, sampled at each frame start
//   wr_valid/wr_ready/din - host byte write handshake
//   fifo_level            - FIFO occupancy
//   thre                  - FIFO empty
//   temt                  - FIFO empty and serialiser idle
//   tx                    - serial line, idle high
// Optional macro UART_TX_CTS_EN adds input cts_n (active low): a new frame
// only starts while cts_n=0; a frame already started always completes.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int  FIFO_DEPTH = 16,
  parameter int  OVERSAMPLE = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_pulse,
  input  logic             set_break,
  input  logic             sticky_parity,
  input  logic             eps,
  input  logic             pen,
  input  logic             stb,
  input  logic [1:0]       wls,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       din,
  output logic [LVL_W-1:0] fifo_level,
  output logic             thre,
  output logic             temt,
  output logic             tx
`ifdef UART_TX_CTS_EN
  ,
  input  logic             cts_n
`endif
);

  // Counter must reach 2*OVERSAMPLE-1 for a two-bit stop period.
  localparam int CNT_W = $clog2(2 * OVERSAMPLE);
  localparam logic [CNT_W-1:0] LIM_1BIT  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] LIM_15BIT = CNT_W'((OVERSAMPLE * 3) / 2 - 1);
  localparam logic [CNT_W-1:0] LIM_2BIT  = CNT_W'(2 * OVERSAMPLE - 1);

  tx_state_t        state_reg;
  logic [CNT_W-1:0] tick_cnt_reg;
  logic [CNT_W-1:0] tick_limit;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       frame_data_reg;
  lcr_cfg_t         cfg_reg;
  logic             tx_reg;

  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             cts_ok;
  logic             start_frame;
  logic             last_bit;

`ifdef UART_TX_CTS_EN
  assign cts_ok = ~cts_n;
`else
  assign cts_ok = 1'b1;
`endif

  uart_sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .wr_en(wr_valid),
    .din  (din),
    .rd_en(start_frame),
    .dout (fifo_dout),
    .level(fifo_level),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign wr_ready = ~fifo_full;
  assign thre     = fifo_empty;
  assign temt     = fifo_empty && (state_reg == IDLE);
  // Break overrides the registered line value only at the pin.
  assign tx       = tx_reg & ~set_break;

  // Only the stop period can be longer than one bit.
  always_comb begin
    tick_limit = LIM_1BIT;
    if (state_reg == STOP && cfg_reg.stb)
      tick_limit = (cfg_reg.wls == WLS_5) ? LIM_15BIT : LIM_2BIT;
  end

  // A frame starts on a tick either from IDLE or at the final tick of STOP,
  // which chains frames with no idle gap.
  assign start_frame = baud_pulse && !fifo_empty && cts_ok &&
                       ((state_reg == IDLE) ||
                        (state_reg == STOP && tick_cnt_reg == tick_limit));

  assign last_bit = (bit_idx_reg == ({1'b0, cfg_reg.wls} + 3'd4));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      tick_cnt_reg   <= '0;
      bit_idx_reg    <= '0;
      frame_data_reg <= '0;
      cfg_reg        <= '0;
      tx_reg         <= 1'b1;
    end else if (start_frame) begin
      state_reg      <= START;
      tick_cnt_reg   <= '0;
      bit_idx_reg    <= '0;
      frame_data_reg <= fifo_dout;
      cfg_reg        <= '{wls: wls, pen: pen, eps: eps, sticky: sticky_parity, stb: stb};
      tx_reg         <= 1'b0;
    end else if (state_reg != IDLE && baud_pulse) begin
      if (tick_cnt_reg == tick_limit) begin
        tick_cnt_reg <= '0;
        case (state_reg)
          START: begin
            state_reg   <= DATA;
            bit_idx_reg <= '0;
            tx_reg      <= frame_data_reg[0];
          end
          DATA: begin
            if (last_bit) begin
              if (cfg_reg.pen) begin
                state_reg <= PARITY;
                tx_reg    <= calc_parity(frame_data_reg, cfg_reg.wls, cfg_reg.eps, cfg_reg.sticky);
              end else begin
                state_reg <= STOP;
                tx_reg    <= 1'b1;
              end
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= frame_data_reg[bit_idx_reg + 3'd1];
            end
          end
          PARITY: begin
            state_reg <= STOP;
            tx_reg    <= 1'b1;
          end
          STOP: begin
            // Reached only when no chained frame starts this tick.
            state_reg <= IDLE;
            tx_reg    <= 1'b1;
          end
          default: begin
            state_reg <= IDLE;
            tx_reg    <= 1'b1;
          end
        endcase
      end else begin
        tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param: directed bench for uart_tx_fifo_param with
// FIFO_DEPTH=4, OVERSAMPLE=16 and a baud tick every 6 clocks. Line bits are
// sampled mid-bit by counting ticks from the start-bit edge.
module tb_uart_tx_fifo_param;

  localparam int OS = 16;

  logic       clk;
  logic       rst;
  logic       baud_pulse;
  logic       set_break;
  logic       sticky_parity;
  logic       eps;
  logic       pen;
  logic       stb;
  logic [1:0] wls;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] din;
  logic [2:0] fifo_level;
  logic       thre;
  logic       temt;
  logic       tx;
`ifdef UART_TX_CTS_EN
  logic       cts_n;
`endif

  bit         baud_en;
  int         bdiv;
  int         n_vec;
  int         n_miss;

  uart_tx_fifo_param #(
    .FIFO_DEPTH(4),
    .OVERSAMPLE(OS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_pulse   (baud_pulse),
    .set_break    (set_break),
    .sticky_parity(sticky_parity),
    .eps          (eps),
    .pen          (pen),
    .stb          (stb),
    .wls          (wls),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .din          (din),
    .fifo_level   (fifo_level),
    .thre         (thre),
    .temt         (temt),
    .tx           (tx)
`ifdef UART_TX_CTS_EN
    ,
    .cts_n        (cts_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick generator: one-cycle pulse every 6 clocks while enabled.
  initial begin
    baud_pulse = 1'b0;
    bdiv = 0;
    forever begin
      @(negedge clk);
      bdiv = (bdiv == 5) ? 0 : bdiv + 1;
      baud_pulse = baud_en && (bdiv == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n baud ticks, returning on the negedge after the n-th tick.
  task automatic wait_ticks(input int n);
    if (n <= 0) return;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!baud_pulse) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    din = b;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Bounded wait for the start-bit edge; returns on the negedge after it.
  task automatic wait_fall(input string tag);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start"}, tx, 1'b0);
  endtask

  // Check nbits line bits (bit k of 'bits' = k-th bit on the wire, start
  // first) at mid-bit, then stop one tick before the frame's last tick.
  task automatic recv_frame(input string tag, input logic [15:0] bits, input int nbits,
                            input int total, input bit sync);
    int elapsed;
    if (sync) wait_fall(tag);
    elapsed = 0;
    for (int k = 0; k < nbits; k++) begin
      wait_ticks(OS * k + OS / 2 - elapsed);
      elapsed = OS * k + OS / 2;
      check($sformatf("%s_b%0d", tag, k), tx, bits[k]);
    end
    wait_ticks(total - 1 - elapsed);
    $display("frame %s: %0d bits sampled", tag, nbits);
  endtask

  // 8N1 frame image: start, 8 data bits LSB first, stop.
  function automatic logic [15:0] f8n(input logic [7:0] b);
    return {6'b0, 1'b1, b, 1'b0};
  endfunction

  task automatic set_cfg(input logic [1:0] w, input logic p, input logic e,
                         input logic s, input logic sb);
    wls = w;
    pen = p;
    eps = e;
    sticky_parity = s;
    stb = sb;
  endtask

  logic [7:0] t3_bytes [6];
  bit         seen_low;

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    baud_en = 1'b1;
    set_break = 1'b0;
    wr_valid = 1'b0;
    din = 8'h00;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef UART_TX_CTS_EN
    cts_n = 1'b0;
`endif
    t3_bytes = '{8'h3C, 8'h81, 8'h5A, 8'hF0, 8'h07, 8'hC3};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_tx", tx, 1'b1);
    check("rst_lvl", fifo_level, 3'd0);
    check("rst_thre", thre, 1'b1);
    check("rst_temt", temt, 1'b1);
    check("rst_rdy", wr_ready, 1'b1);

    // 1: A5, 8 bits, even parity, 2 stop bits; LCR change mid-frame ignored
    set_cfg(2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
    write_byte(8'hA5);
    check("t1_lvl", fifo_level, 3'd1);
    check("t1_thre", thre, 1'b0);
    wait_fall("t1");
    set_cfg(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    recv_frame("t1", 16'h0D4A, 12, 192, 1'b0);
    check("t1_temt_end-1", temt, 1'b0);
    wait_ticks(1);
    check("t1_temt_end", temt, 1'b1);

    // 2: 0F, 5 bits, odd parity, 1.5 stop bits
    write_byte(8'h0F);
    recv_frame("t2", 16'h00DE, 8, 136, 1'b1);
    check("t2_temt_end-1", temt, 1'b0);
    check("t2_tx_end-1", tx, 1'b1);
    wait_ticks(1);
    check("t2_temt_end", temt, 1'b1);

    // 2b: FF, 6 bits, sticky parity with eps=1, 2 stop bits
    set_cfg(2'b01, 1'b1, 1'b1, 1'b1, 1'b1);
    write_byte(8'hFF);
    recv_frame("t2b", 16'h037E, 10, 160, 1'b1);
    wait_ticks(1);
    check("t2b_temt", temt, 1'b1);

    // 3: fill the 4-deep FIFO, then 6 chained 8N1 frames
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    baud_en = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      din = t3_bytes[i];
      wr_valid = 1'b1;
      check($sformatf("t3_rdy%0d", i), wr_ready, (i < 4) ? 1 : 0);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("t3_peak", fifo_level, 3'd4);
    baud_en = 1'b1;
    wait_fall("t3_f0");
    check("t3_lvl_pop", fifo_level, 3'd3);
    write_byte(t3_bytes[4]);
    check("t3_lvl_refill", fifo_level, 3'd4);
    check("t3_rdy_full", wr_ready, 1'b0);
    recv_frame("t3_f0", f8n(t3_bytes[0]), 10, 160, 1'b0);
    for (int f = 1; f < 6; f++) begin
      wait_ticks(1);
      if (f == 1) begin
        write_byte(t3_bytes[5]);
        check("t3_lvl_f1", fifo_level, 3'd4);
      end
      recv_frame($sformatf("t3_f%0d", f), f8n(t3_bytes[f]), 10, 160, 1'b0);
    end
    check("t3_temt_end-1", temt, 1'b0);
    wait_ticks(1);
    check("t3_temt_end", temt, 1'b1);
    check("t3_thre_end", thre, 1'b1);

    // 4: break during DATA of frame 96, released mid-frame 69
    baud_en = 1'b0;
    repeat (3) @(negedge clk);
    write_byte(8'h96);
    write_byte(8'h69);
    baud_en = 1'b1;
    wait_fall("t4");
    check("t4_lvl", fifo_level, 3'd1);
    wait_ticks(40);
    set_break = 1'b1;
    #1;
    check("t4_brk_on", tx, 1'b0);
    wait_ticks(120);
    check("t4_brk_drain", fifo_level, 3'd0);
    check("t4_brk_tx", tx, 1'b0);
    wait_ticks(72);
    set_break = 1'b0;
    #1;
    check("t4_brk_rel", tx, 1'b1);
    wait_ticks(16);
    check("t4_f2_b5", tx, 1'b0);
    wait_ticks(71);
    check("t4_temt_end-1", temt, 1'b0);
    wait_ticks(1);
    check("t4_temt_end", temt, 1'b1);

    // 5: reset mid-PARITY with 3 bytes still queued
    set_cfg(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    baud_en = 1'b0;
    repeat (3) @(negedge clk);
    write_byte(8'h03);
    write_byte(8'h12);
    write_byte(8'h34);
    write_byte(8'h56);
    baud_en = 1'b1;
    wait_fall("t5");
    check("t5_lvl", fifo_level, 3'd3);
    wait_ticks(152);
    check("t5_par", tx, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_tx", tx, 1'b1);
    check("t5_lvl0", fifo_level, 3'd0);
    check("t5_thre", thre, 1'b1);
    check("t5_temt", temt, 1'b1);
    check("t5_rdy", wr_ready, 1'b1);
    seen_low = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) seen_low = 1'b1;
    end
    check("t5_quiet", seen_low, 1'b0);

`ifdef UART_TX_CTS_EN
    // 6: CTS holds frame starts; an in-progress frame completes
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    baud_en = 1'b0;
    repeat (3) @(negedge clk);
    cts_n = 1'b1;
    write_byte(8'hA1);
    write_byte(8'h5E);
    baud_en = 1'b1;
    seen_low = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (tx !== 1'b1) seen_low = 1'b1;
    end
    check("t6_hold", seen_low, 1'b0);
    check("t6_lvl_hold", fifo_level, 3'd2);
    cts_n = 1'b0;
    begin
      int n;
      n = 0;
      while (tx !== 1'b0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("t6_go", tx, 1'b0);
      check("t6_go_latency", (n <= 6) ? 1 : 0, 1);
    end
    cts_n = 1'b1;
    recv_frame("t6_f1", f8n(8'hA1), 10, 160, 1'b0);
    wait_ticks(1);
    check("t6_tx_held", tx, 1'b1);
    check("t6_lvl_held", fifo_level, 3'd1);
    check("t6_temt_held", temt, 1'b0);
    seen_low = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) seen_low = 1'b1;
    end
    check("t6_hold2", seen_low, 1'b0);
    cts_n = 1'b0;
    recv_frame("t6_f2", f8n(8'h5E), 10, 160, 1'b1);
    wait_ticks(1);
    check("t6_temt_end", temt, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
